// File: rtl/libv_pkg.sv
// libv_pkg -- shared helpers for library blocks.
//   LIBV_FF_W : widest vector the find-first helper handles.
//   libv_ff1  : lowest-set-bit search. Callers zero-extend their vector to
//               LIBV_FF_W bits and take back a one-hot value and a binary index.
//               An all-zero input gives oh=0, idx=0.
package libv_pkg;

  localparam int LIBV_FF_W = 64;

  function automatic void libv_ff1(input  logic [LIBV_FF_W-1:0] v,
                                   output logic [LIBV_FF_W-1:0] oh,
                                   output int                   idx);
    oh  = '0;
    idx = 0;
    // The scan runs from the top bit down, so the last hit is the lowest set bit.
    for (int i = LIBV_FF_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
        idx   = i;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_masked_mask.sv
// mask -- thermometer mask generator.
//   W : vector width (power of two).
//   x : in  $clog2(W)  mask index.
//   m : out W          m = (1 << x) - 1, so bits below x are set.
module mask #(
  parameter int W = 8
) (
  input  logic [$clog2(W)-1:0] x,
  output logic [W-1:0]         m
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign m[i] = (int'(x) > i);
  end

endmodule

// File: rtl/rr_arbiter_masked.sv
// rr_arbiter_masked -- round-robin arbiter with a held valid/ack grant.
//   N       : number of requesters (power of two, >= 2).
//   clk     : in  1            clock.
//   arst_n  : in  1            asynchronous active-low reset.
//   req     : in  N            request vector.
//   ack     : in  1            consumer accepts the presented grant.
//   gnt_vld : out 1            a grant is presented.
//   gnt     : out N            one-hot grant, zero when gnt_vld=0.
//   gnt_idx : out $clog2(N)    index of the granted requester.
// Optional: define RR_ARBITER_MASKED_ASSERT_EN to compile in SVA checks.
module rr_arbiter_masked
  import libv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic                 gnt_vld,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  typedef logic [N-1:0]  vec_t;
  typedef logic [IW-1:0] idx_t;
  typedef enum logic {IDLE, GRANT} state_e;

  state_e state_q, state_d;
  idx_t   ptr_q, ptr_d;
  vec_t   gnt_q, gnt_d;
  idx_t   idx_q, idx_d;

  logic   accept;
  idx_t   ptr_sel;
  vec_t   m, hi, cand, sel_oh;
  idx_t   sel_idx;

  logic [LIBV_FF_W-1:0] ff_oh;
  int                   ff_idx;
  logic                 unused_ff;

  // On an accepted grant the search starts just past the granted requester
  // in the same edge, so the old ptr must not be used for that re-arbitration.
  // N is a power of two, so the IW-bit add wraps to 0 for free.
  assign accept  = (state_q == GRANT) && ack;
  assign ptr_sel = accept ? idx_q + idx_t'(1) : ptr_q;

  mask #(.W(N)) u_mask (
    .x (ptr_sel),
    .m (m)
  );

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign hi   = req & ~m;
  assign cand = (|hi) ? hi : req;

  always_comb begin
    libv_ff1(LIBV_FF_W'(cand), ff_oh, ff_idx);
    sel_oh  = ff_oh[N-1:0];
    sel_idx = idx_t'(ff_idx);
  end

  // Upper search bits are always zero for an N-bit candidate.
  assign unused_ff = ^{ff_oh, ff_idx};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = sel_oh;
          idx_d   = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_d = ptr_sel;
          if (|req) begin
            gnt_d = sel_oh;
            idx_d = sel_idx;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt_vld = (state_q == GRANT);
  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;

`ifdef RR_ARBITER_MASKED_ASSERT_EN
  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("rr_arbiter_masked: N must be a power of two >= 2");
  end

  a_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    gnt_vld ? $onehot(gnt) : (gnt == '0));

  a_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (gnt_vld && !ack) |=> ($stable(gnt) && $stable(gnt_idx)));

  a_idx: assert property (@(posedge clk) disable iff (!arst_n)
    gnt_vld |-> gnt[gnt_idx]);
`endif

endmodule

// File: tb/tb_rr_arbiter_masked.sv
// Scoreboard bench for rr_arbiter_masked (N=4). Stimulus pushes the expected
// outputs for the following cycle; a negedge monitor pops and compares.
module tb_rr_arbiter_masked;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         gnt_vld;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;

  rr_arbiter_masked #(.N(N)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (req),
    .ack     (ack),
    .gnt_vld (gnt_vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        vld;
    logic [3:0]  gnt;
    logic [1:0]  idx;
  } exp_t;

  exp_t        q[$];
  int unsigned cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input exp_t e);
    n_tests++;
    if (gnt_vld !== e.vld || gnt !== e.gnt || gnt_idx !== e.idx) begin
      n_fail++;
      $display("FAIL %s: got vld=%0b gnt=%b idx=%0d, want vld=%0b gnt=%b idx=%0d",
               name, gnt_vld, gnt, gnt_idx, e.vld, e.gnt, e.idx);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc <= cnt) begin
        e = q.pop_front();
        chk($sformatf("cyc%0d", e.cyc), e);
      end
    end
  end

  // Drive one cycle of inputs and post the outputs expected after the next edge.
  task automatic cyc(input logic [3:0] r, input logic a,
                     input logic v, input logic [3:0] g, input logic [1:0] i);
    exp_t e;
    @(posedge clk);
    #1;
    req   = r;
    ack   = a;
    e.cyc = cnt + 1;
    e.vld = v;
    e.gnt = g;
    e.idx = i;
    q.push_back(e);
  endtask

  // Assert reset away from any edge and check outputs clear without a clock.
  task automatic do_reset(input string name);
    exp_t z;
    z = '{0, 1'b0, 4'b0000, 2'd0};
    @(posedge clk);
    @(negedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk(name, z);
    #2;
    arst_n = 1'b1;
  endtask

  initial begin
    exp_t z;
    z = '{0, 1'b0, 4'b0000, 2'd0};
    #1;
    chk("reset_state", z);
    #11;
    arst_n = 1'b1;

    // Idle with no requests.
    repeat (5) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);

    // First grant, then held while req changes.
    cyc(4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1);
    repeat (3) cyc(4'b1000, 1'b0, 1'b1, 4'b0010, 2'd1);

    // Accept: ptr=2 -> idx 3; accept again: ptr wraps to 0 -> idx 1.
    cyc(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3);
    cyc(4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);

    do_reset("rst_before_stream");

    // Back-to-back grants with ack held high.
    cyc(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
    cyc(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);

    // Final accept with no requests -> IDLE; ack in IDLE is ignored.
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    repeat (3) cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    cyc(4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);

    // Reset while granting, then restart from ptr=0.
    do_reset("rst_mid_grant");
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);

    begin
      int budget;
      budget = 20;
      while (q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      if (q.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
